// File: rtl/frog_game_ctrl.sv
// -----------------------------------------------------------------------------
// frog_game_ctrl
//
// Game-flow sequencer for the frog VGA game. Tracks lives, level and score and
// freezes / restarts the sprites through the IDLE, PLAY, DYING, WIN and OVER
// phases. Every decision is taken on the frame-end i_animate strobe, so game
// time advances in frames, not clocks. All outputs are registered.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_animate   one-cycle frame-end strobe
//   i_start     start button (synchronised, active-high)
//   i_hit       frog/obstacle overlap (level)
//   i_frog_y1   frog top edge
//   o_frog_rst  one-cycle pulse returning the frog to its spawn point
//   o_freeze    high: sprites hold position
//   o_frog_vis  frog drawn when high
//   o_lives     remaining lives
//   o_level     current level, 1..MAX_LEVEL
//   o_score     score, saturating at 255
//   o_state     IDLE=0, PLAY=1, DYING=2, WIN=3, OVER=4
// -----------------------------------------------------------------------------
module frog_game_ctrl #(
   parameter int LIVES        = 3,
   parameter int DEATH_FRAMES = 60,
   parameter int WIN_FRAMES   = 30,
   parameter int GOAL_Y       = 40,
   parameter int MAX_LEVEL    = 7,
   parameter int FLASH_SH     = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_animate,
   input  logic        i_start,
   input  logic        i_hit,
   input  logic [11:0] i_frog_y1,
   output logic        o_frog_rst,
   output logic        o_freeze,
   output logic        o_frog_vis,
   output logic [1:0]  o_lives,
   output logic [2:0]  o_level,
   output logic [7:0]  o_score,
   output logic [2:0]  o_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_DYING = 3'd2,
      ST_WIN   = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
   localparam logic [2:0]  LEVEL_MAX  = 3'(MAX_LEVEL);
   localparam logic [7:0]  DEATH_LAST = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0]  WIN_LAST   = 8'(WIN_FRAMES - 1);
   localparam logic [11:0] GOAL_LINE  = 12'(GOAL_Y);

   state_t      state_q, state_d;
   logic [1:0]  lives_q, lives_d;
   logic [2:0]  level_q, level_d;
   logic [7:0]  score_q, score_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic        start_pend_q, start_pend_d;
   logic        start_q, start_d;
   logic        frog_rst_q, frog_rst_d;
   logic        freeze_q, freeze_d;
   logic        vis_q, vis_d;

   logic        start_edge;
   logic        start_req;
   logic [8:0]  score_sum;

   always_comb begin
      start_d    = i_start;
      start_edge = i_start & ~start_q;
      // An edge arriving on the same clock as the animate still counts.
      start_req  = start_pend_q | start_edge;
      // Score grows 9 bits wide so the carry reveals overflow before clamping.
      score_sum  = {1'b0, score_q} + {6'd0, level_q};

      state_d      = state_q;
      lives_d      = lives_q;
      level_d      = level_q;
      score_d      = score_q;
      fcnt_d       = fcnt_q;
      start_pend_d = 1'b0;
      frog_rst_d   = 1'b0;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            start_pend_d = start_req;
            if (i_animate && start_req) begin
               lives_d      = LIVES_INIT;
               level_d      = 3'd1;
               score_d      = 8'd0;
               frog_rst_d   = 1'b1;
               start_pend_d = 1'b0;
               state_d      = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (i_animate) begin
               // Collision wins over reaching the goal in the same frame.
               if (i_hit) begin
                  state_d = ST_DYING;
               end else if (i_frog_y1 < GOAL_LINE) begin
                  score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                  state_d = ST_WIN;
               end
            end
         end
         ST_DYING: begin
            if (i_animate) begin
               if (fcnt_q == DEATH_LAST) begin
                  lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                  if (lives_q <= 2'd1) begin
                     state_d = ST_OVER;
                  end else begin
                     frog_rst_d = 1'b1;
                     state_d    = ST_PLAY;
                  end
               end else begin
                  fcnt_d = fcnt_q + 8'd1;
               end
            end
         end
         ST_WIN: begin
            if (i_animate) begin
               if (fcnt_q == WIN_LAST) begin
                  level_d    = (level_q < LEVEL_MAX) ? level_q + 3'd1 : LEVEL_MAX;
                  frog_rst_d = 1'b1;
                  state_d    = ST_PLAY;
               end else begin
                  fcnt_d = fcnt_q + 8'd1;
               end
            end
         end
         default: begin
            if (i_animate) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      if (state_d != state_q) begin
         fcnt_d = 8'd0;
      end
      if (state_d == ST_OVER) begin
         lives_d = 2'd0;
      end

      // Sprite controls are derived from the next state so they register
      // together with it and change in the same cycle as o_state.
      freeze_d = (state_d != ST_PLAY);
      case (state_d)
         ST_DYING: vis_d = ~fcnt_d[FLASH_SH];
         ST_OVER:  vis_d = 1'b0;
         default:  vis_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         lives_q      <= LIVES_INIT;
         level_q      <= 3'd1;
         score_q      <= 8'd0;
         fcnt_q       <= 8'd0;
         start_pend_q <= 1'b0;
         start_q      <= 1'b0;
         frog_rst_q   <= 1'b0;
         freeze_q     <= 1'b1;
         vis_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         level_q      <= level_d;
         score_q      <= score_d;
         fcnt_q       <= fcnt_d;
         start_pend_q <= start_pend_d;
         start_q      <= start_d;
         frog_rst_q   <= frog_rst_d;
         freeze_q     <= freeze_d;
         vis_q        <= vis_d;
      end
   end

   assign o_frog_rst = frog_rst_q;
   assign o_freeze   = freeze_q;
   assign o_frog_vis = vis_q;
   assign o_lives    = lives_q;
   assign o_level    = level_q;
   assign o_score    = score_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frog_game_ctrl
//
// Directed bench for frog_game_ctrl with default parameters. Each scenario
// task drives stimulus and compares outputs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_frog_game_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_animate;
   logic        i_start;
   logic        i_hit;
   logic [11:0] i_frog_y1;
   logic        o_frog_rst;
   logic        o_freeze;
   logic        o_frog_vis;
   logic [1:0]  o_lives;
   logic [2:0]  o_level;
   logic [7:0]  o_score;
   logic [2:0]  o_state;

   int checks = 0;
   int errors = 0;

   frog_game_ctrl dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_animate  (i_animate),
      .i_start    (i_start),
      .i_hit      (i_hit),
      .i_frog_y1  (i_frog_y1),
      .o_frog_rst (o_frog_rst),
      .o_freeze   (o_freeze),
      .o_frog_vis (o_frog_vis),
      .o_lives    (o_lives),
      .o_level    (o_level),
      .o_score    (o_score),
      .o_state    (o_state)
   );

   always #5 i_clk = ~i_clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns later.
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   // One idle clock followed by a one-cycle animate strobe.
   task automatic frame();
      cyc();
      i_animate = 1'b1;
      cyc();
      i_animate = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_animate = 1'b0; i_start = 1'b0; i_hit = 1'b0;
      i_frog_y1 = 12'd100;
      repeat (3) cyc();
      checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", o_state); end
      checks++; if (o_lives !== 2'd3) begin errors++; $display("FAIL rst_lives got %0d want 3", o_lives); end
      checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL rst_level got %0d want 1", o_level); end
      checks++; if (o_score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d want 0", o_score); end
      checks++; if (o_freeze !== 1'b1) begin errors++; $display("FAIL rst_freeze got %0b want 1", o_freeze); end
      checks++; if (o_frog_vis !== 1'b1) begin errors++; $display("FAIL rst_vis got %0b want 1", o_frog_vis); end
      checks++; if (o_frog_rst !== 1'b0) begin errors++; $display("FAIL rst_frog_rst got %0b want 0", o_frog_rst); end
      i_rst_n = 1'b1;
      frame();
      checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL idle_no_start got %0d want 0", o_state); end
   endtask

   task automatic test_start();
      i_start = 1'b1; cyc(); i_start = 1'b0; cyc();
      frame();
      checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL start_state got %0d want 1", o_state); end
      checks++; if (o_freeze !== 1'b0) begin errors++; $display("FAIL start_freeze got %0b want 0", o_freeze); end
      checks++; if (o_frog_rst !== 1'b1) begin errors++; $display("FAIL start_frog_rst got %0b want 1", o_frog_rst); end
      checks++; if (o_lives !== 2'd3) begin errors++; $display("FAIL start_lives got %0d want 3", o_lives); end
      cyc();
      checks++; if (o_frog_rst !== 1'b0) begin errors++; $display("FAIL start_rst_width got %0b want 0", o_frog_rst); end
      // Held start must not create a second request.
      i_start = 1'b1;
      frame();
      checks++; if (o_frog_rst !== 1'b0) begin errors++; $display("FAIL held_start_rst got %0b want 0", o_frog_rst); end
      frame();
      checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL held_start_state got %0d want 1", o_state); end
      i_start = 1'b0;
      // Hit glitch between frames is ignored.
      cyc(); i_hit = 1'b1; cyc(); i_hit = 1'b0;
      frame();
      checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL hit_glitch got %0d want 1", o_state); end
      // Top edge exactly on the goal line is not a goal.
      i_frog_y1 = 12'd40;
      frame();
      checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL goal_boundary got %0d want 1", o_state); end
      i_frog_y1 = 12'd100;
   endtask

   // Plays out frames 2..60 of a death (first frame already taken by caller).
   task automatic run_death(input logic [1:0] lives_before, input logic [2:0] state_after,
                            input logic [1:0] lives_after);
      logic vis_exp;
      for (int k = 1; k < 60; k++) begin
         frame();
         vis_exp = ((k >> 3) & 1) == 0;
         checks++; if (o_state !== 3'd2 || o_frog_vis !== vis_exp || o_lives !== lives_before) begin
            errors++;
            $display("FAIL dying_frame%0d got state=%0d vis=%0b lives=%0d want state=2 vis=%0b lives=%0d",
                     k, o_state, o_frog_vis, o_lives, vis_exp, lives_before);
         end
      end
      frame();
      checks++; if (o_state !== state_after) begin errors++; $display("FAIL death_end_state got %0d want %0d", o_state, state_after); end
      checks++; if (o_lives !== lives_after) begin errors++; $display("FAIL death_end_lives got %0d want %0d", o_lives, lives_after); end
      checks++; if (o_frog_rst !== (state_after == 3'd1)) begin errors++; $display("FAIL death_end_rst got %0b want %0b", o_frog_rst, state_after == 3'd1); end
   endtask

   task automatic test_death();
      i_hit = 1'b1; frame(); i_hit = 1'b0;
      checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL hit_state got %0d want 2", o_state); end
      checks++; if (o_freeze !== 1'b1) begin errors++; $display("FAIL hit_freeze got %0b want 1", o_freeze); end
      run_death(2'd3, 3'd1, 2'd2);
      checks++; if (o_freeze !== 1'b0) begin errors++; $display("FAIL respawn_freeze got %0b want 0", o_freeze); end
      cyc();
      checks++; if (o_frog_rst !== 1'b0) begin errors++; $display("FAIL respawn_rst_width got %0b want 0", o_frog_rst); end
   endtask

   task automatic test_hit_priority();
      i_hit = 1'b1; i_frog_y1 = 12'd10; frame(); i_hit = 1'b0; i_frog_y1 = 12'd100;
      checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL prio_state got %0d want 2", o_state); end
      checks++; if (o_score !== 8'd0) begin errors++; $display("FAIL prio_score got %0d want 0", o_score); end
      run_death(2'd2, 3'd1, 2'd1);
   endtask

   task automatic test_win_saturate();
      int exp_score = 0;
      int exp_level = 1;
      int guard = 0;
      while (exp_score < 255 && guard < 60) begin
         guard++;
         i_frog_y1 = (guard == 1) ? 12'd39 : 12'd10;
         frame();
         i_frog_y1 = 12'd100;
         exp_score = (exp_score + exp_level > 255) ? 255 : exp_score + exp_level;
         checks++; if (o_state !== 3'd3 || o_score !== 8'(exp_score) || o_freeze !== 1'b1) begin
            errors++;
            $display("FAIL win%0d_enter got state=%0d score=%0d freeze=%0b want state=3 score=%0d freeze=1",
                     guard, o_state, o_score, o_freeze, exp_score);
         end
         repeat (29) frame();
         checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL win%0d_hold got %0d want 3", guard, o_state); end
         frame();
         exp_level = (exp_level < 7) ? exp_level + 1 : 7;
         checks++; if (o_state !== 3'd1 || o_level !== 3'(exp_level) || o_frog_rst !== 1'b1) begin
            errors++;
            $display("FAIL win%0d_exit got state=%0d level=%0d rst=%0b want state=1 level=%0d rst=1",
                     guard, o_state, o_level, o_frog_rst, exp_level);
         end
      end
      checks++; if (o_score !== 8'd255) begin errors++; $display("FAIL score_sat got %0d want 255", o_score); end
      checks++; if (o_level !== 3'd7) begin errors++; $display("FAIL level_cap got %0d want 7", o_level); end
   endtask

   task automatic test_game_over();
      i_hit = 1'b1; frame(); i_hit = 1'b0;
      checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL last_hit got %0d want 2", o_state); end
      // Edge raised while dying is discarded.
      i_start = 1'b1;
      run_death(2'd1, 3'd4, 2'd0);
      checks++; if (o_frog_vis !== 1'b0) begin errors++; $display("FAIL over_vis got %0b want 0", o_frog_vis); end
      checks++; if (o_freeze !== 1'b1) begin errors++; $display("FAIL over_freeze got %0b want 1", o_freeze); end
      frame();
      checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL over_held_start got %0d want 4", o_state); end
      i_start = 1'b0; cyc();
      // Start edge and animate on the same clock.
      i_start = 1'b1; i_animate = 1'b1; cyc(); i_animate = 1'b0; i_start = 1'b0;
      checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL restart_state got %0d want 1", o_state); end
      checks++; if (o_lives !== 2'd3) begin errors++; $display("FAIL restart_lives got %0d want 3", o_lives); end
      checks++; if (o_score !== 8'd0) begin errors++; $display("FAIL restart_score got %0d want 0", o_score); end
      checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL restart_level got %0d want 1", o_level); end
      checks++; if (o_frog_rst !== 1'b1) begin errors++; $display("FAIL restart_rst got %0b want 1", o_frog_rst); end
   endtask

   task automatic test_async_reset();
      i_hit = 1'b1; frame(); i_hit = 1'b0;
      repeat (10) frame();
      checks++; if (o_state !== 3'd2 || o_frog_vis !== 1'b0) begin
         errors++; $display("FAIL pre_reset got state=%0d vis=%0b want state=2 vis=0", o_state, o_frog_vis);
      end
      @(posedge i_clk); #3;
      i_rst_n = 1'b0;
      #1;
      checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL async_state got %0d want 0", o_state); end
      checks++; if (o_frog_vis !== 1'b1) begin errors++; $display("FAIL async_vis got %0b want 1", o_frog_vis); end
      checks++; if (o_freeze !== 1'b1) begin errors++; $display("FAIL async_freeze got %0b want 1", o_freeze); end
      checks++; if (o_lives !== 2'd3) begin errors++; $display("FAIL async_lives got %0d want 3", o_lives); end
      cyc(); cyc();
      i_rst_n = 1'b1;
      frame();
      checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL post_reset_idle got %0d want 0", o_state); end
      i_start = 1'b1; cyc(); i_start = 1'b0;
      frame();
      checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL post_reset_start got %0d want 1", o_state); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_death();
      test_hit_priority();
      test_win_saturate();
      test_game_over();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
